uart_rx_fc: RTL and testbench

- 8N1 UART receiver for the USB-UART bridge pins. Deserialises UART_RX into bytes and buffers them in a small FIFO.
- Presents bytes on a valid/ready stream to fabric logic.
- Drives UART_CTS_N from FIFO fill level so the host pauses transmission before overrun.
- Receive-side counterpart of the fabric UART transmitter on UART_TX.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_rx_fc.sv | 127 ++++++++++++
 tb/tb_uart_rx_fc.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the fabric UART: FSM encoding, frame length and
// baud divider helpers used by both receiver and transmitter.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int FRAME_BITS = 10;

  // Cycles per bit, rounded to nearest.
  function automatic int uart_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic int uart_half(input int clk_hz, input int baud);
    return uart_div(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy counter.
// Read data is show-ahead: o_rd_data always reflects the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_wr_en,
  input  logic [WIDTH-1:0]             i_wr_data,
  input  logic                         i_rd_en,
  output logic [WIDTH-1:0]             o_rd_data,
  output logic                         o_empty,
  output logic                         o_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [$clog2(DEPTH+1)-1:0]   o_count_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic             w_push;
  logic             w_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_pop     = i_rd_en & ~o_empty;
  // A same-cycle pop frees the slot the write lands in.
  assign w_push    = i_wr_en & (~o_full | w_pop);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_count_next = w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CW'(1);
    else if (w_pop && !w_push) w_count_next = r_count - CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
    end
  end

endmodule

// File: rtl/uart_rx_fc.sv
// 8N1 UART receiver with byte FIFO, valid/ready output stream and
// CTS_N flow control derived from FIFO occupancy.
module uart_rx_fc
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int CTS_THRESH = 12
) (
  input  logic                              CLK50M,
  input  logic                              RST_N,
  input  logic                              UART_RX,
  output logic                              UART_CTS_N,
  output logic [7:0]                        m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill,
  output logic                              frame_err,
  output logic                              overrun
);

  localparam int DIV   = uart_div(CLK_HZ, BAUD);
  localparam int HALF  = uart_half(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV);
  localparam int FW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [2:0]       LAST_BIT = 3'(FRAME_BITS - 3);
  localparam logic [FW-1:0]    CTS_LVL  = FW'(CTS_THRESH);

  logic             r_rx_meta, r_rxs, r_rxs_d;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_frame_err, r_overrun, r_cts_n;

  logic             w_tick, w_stop_smp, w_pop, w_room, w_push;
  logic             w_empty, w_full;
  logic [FW-1:0]    w_count_next;

  assign w_tick     = (r_cnt == '0);
  assign w_stop_smp = (r_state == ST_STOP) & w_tick;
  assign w_pop      = m_valid & m_ready;
  assign w_room     = ~w_full | w_pop;
  assign w_push     = w_stop_smp & r_rxs & w_room;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk        (CLK50M),
    .i_rst_n      (RST_N),
    .i_wr_en      (w_push),
    .i_wr_data    (r_shift),
    .i_rd_en      (m_ready),
    .o_rd_data    (m_data),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .o_count      (fill),
    .o_count_next (w_count_next)
  );

  assign m_valid    = ~w_empty;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign UART_CTS_N = r_cts_n;

  always_ff @(posedge CLK50M or negedge RST_N) begin
    if (!RST_N) begin
      r_rx_meta   <= 1'b1;
      r_rxs       <= 1'b1;
      r_rxs_d     <= 1'b1;
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_cts_n     <= 1'b1;
    end else begin
      r_rx_meta   <= UART_RX;
      r_rxs       <= r_rx_meta;
      r_rxs_d     <= r_rxs;
      r_frame_err <= w_stop_smp & ~r_rxs;
      r_overrun   <= w_stop_smp & r_rxs & ~w_room;
      r_cts_n     <= (w_count_next >= CTS_LVL);
      case (r_state)
        ST_IDLE: begin
          if (r_rxs_d && !r_rxs) begin
            r_state <= ST_START;
            r_cnt   <= CNT_HALF;
          end
        end
        ST_START: begin
          // Line back high at mid start bit means a glitch, not a frame.
          if (w_tick) begin
            if (!r_rxs) begin
              r_state <= ST_DATA;
              r_cnt   <= CNT_BIT;
              r_bit   <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift <= {r_rxs, r_shift[7:1]};
            r_cnt   <= CNT_BIT;
            if (r_bit == LAST_BIT) r_state <= ST_STOP;
            else                   r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_STOP: begin
          // Leave mid stop bit so a back-to-back start edge is not missed.
          if (w_tick) r_state <= ST_IDLE;
          else        r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fc.sv
// Scoreboard bench for uart_rx_fc: directed frames, expected bytes queued
// at send time and checked by a monitor on every accepted output byte.
module tb_uart_rx_fc;

  localparam int DIV  = 20;                  // 50 MHz / 2.5 Mbaud
  localparam int HALF = 10;
  localparam int LAT  = 3 + HALF + 9 * DIV;  // start drive to stop-sample edge

  logic       CLK50M = 1'b0;
  logic       RST_N = 1'b0;
  logic       UART_RX = 1'b1;
  logic       m_ready = 1'b0;
  logic       UART_CTS_N;
  logic [7:0] m_data;
  logic       m_valid;
  logic [4:0] fill;
  logic       frame_err;
  logic       overrun;

  int tests = 0, failed = 0;
  int ferr_cnt = 0, ovr_cnt = 0;
  int cyc = 0, start_cyc = 0, rise_cyc = -1;
  bit cts_en = 1'b0;
  logic [7:0] exp_q [$];

  uart_rx_fc #(
    .CLK_HZ(50000000), .BAUD(2500000), .FIFO_DEPTH(16), .CTS_THRESH(12)
  ) dut (
    .CLK50M(CLK50M), .RST_N(RST_N), .UART_RX(UART_RX), .UART_CTS_N(UART_CTS_N),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .fill(fill),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 CLK50M = ~CLK50M;
  always @(posedge CLK50M) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK50M);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input bit pop_at_stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      UART_RX = fr[j];
      if (j == 0) start_cyc = cyc;
      for (int k = 0; k < DIV; k++) begin
        if (pop_at_stop) m_ready = (j * DIV + k == LAT - 1);
        tick();
      end
    end
    UART_RX = 1'b1;
  endtask

  task automatic pop1();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    m_ready = 1'b1;
    while (fill != 0 && n < maxc) begin
      tick();
      n++;
    end
    m_ready = 1'b0;
    chk("drain_done", fill, 0);
  endtask

  // Monitor: pops scoreboard on every handshake, counts error pulses.
  initial begin
    logic prev_valid;
    logic [7:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge CLK50M);
      if (RST_N) begin
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_byte: got %0h, none expected", m_data);
          end else begin
            e = exp_q.pop_front();
            chk("rx_byte", m_data, e);
          end
        end
        if (frame_err) ferr_cnt++;
        if (overrun)   ovr_cnt++;
        if (m_valid && !prev_valid) rise_cyc = cyc;
        if (cts_en) chk("cts_level", UART_CTS_N, (fill >= 5'd12) ? 1 : 0);
      end
      prev_valid = m_valid;
    end
  end

  initial begin
    logic [9:0] fr;
    repeat (3) tick();
    chk("reset_cts", UART_CTS_N, 1);
    chk("reset_valid", m_valid, 0);
    chk("reset_fill", fill, 0);
    chk("reset_data", m_data, 0);
    chk("reset_ferr", frame_err, 0);
    chk("reset_ovr", overrun, 0);
    RST_N = 1'b1;
    tick();
    chk("cts_after_release", UART_CTS_N, 0);
    cts_en = 1'b1;

    // Single byte
    repeat (5) tick();
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 1'b0);
    chk("latency", rise_cyc - start_cyc, LAT);
    chk("a5_fill", fill, 1);
    chk("a5_data", m_data, 8'hA5);
    pop1();
    chk("a5_fill_after_pop", fill, 0);
    chk("a5_valid_after_pop", m_valid, 0);

    // Start glitch shorter than half a bit, then bad stop bit
    UART_RX = 1'b0;
    repeat (5) tick();
    UART_RX = 1'b1;
    repeat (30) tick();
    chk("glitch_fill", fill, 0);
    chk("glitch_ferr", ferr_cnt, 0);
    send_byte(8'h3C, 1'b0, 1'b0);
    repeat (5) tick();
    chk("ferr_count", ferr_cnt, 1);
    chk("ferr_fill", fill, 0);
    chk("ferr_no_ovr", ovr_cnt, 0);

    // Flow control threshold
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, 1'b0);
      if (i == 10) begin
        chk("fc_fill11", fill, 11);
        chk("fc_cts11", UART_CTS_N, 0);
      end
    end
    chk("fc_fill12", fill, 12);
    chk("fc_cts12", UART_CTS_N, 1);
    pop1();
    chk("fc_fill_pop", fill, 11);
    chk("fc_cts_pop", UART_CTS_N, 0);
    drain(40);

    // Overrun on the 17th byte
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'h10 + 8'(i));
      send_byte(8'h10 + 8'(i), 1'b1, 1'b0);
      if (i == 15) begin
        chk("ovr_none_yet", ovr_cnt, 0);
        chk("ovr_fill16", fill, 16);
      end
    end
    chk("ovr_count", ovr_cnt, 1);
    chk("ovr_fill", fill, 16);
    chk("ovr_no_ferr", ferr_cnt, 1);

    // Push/pop collision while full
    exp_q.push_back(8'h21);
    send_byte(8'h21, 1'b1, 1'b1);
    m_ready = 1'b0;
    chk("coll_fill", fill, 16);
    chk("coll_no_ovr", ovr_cnt, 1);
    drain(40);
    chk("coll_queue_empty", exp_q.size(), 0);

    // Reset in the middle of data bit 4 of 0x55
    repeat (5) tick();
    fr = {1'b1, 8'h55, 1'b0};
    for (int j = 0; j < 5; j++) begin
      UART_RX = fr[j];
      repeat (DIV) tick();
    end
    UART_RX = fr[5];
    repeat (HALF) tick();
    cts_en = 1'b0;
    RST_N = 1'b0;
    UART_RX = 1'b1;
    repeat (3) tick();
    chk("rst_mid_cts", UART_CTS_N, 1);
    chk("rst_mid_fill", fill, 0);
    chk("rst_mid_valid", m_valid, 0);
    RST_N = 1'b1;
    tick();
    chk("rst_mid_cts_release", UART_CTS_N, 0);
    cts_en = 1'b1;
    repeat (5) tick();
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1, 1'b0);
    chk("rst_81_fill", fill, 1);
    drain(10);
    chk("rst_no_ferr", ferr_cnt, 1);
    chk("rst_no_ovr", ovr_cnt, 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
